// File: rtl/memory_wishbone_bridge_pkg.sv
// Shared definitions for the memory-to-Wishbone bridge: FSM encoding,
// termination causes and timer sizing.
package memory_wishbone_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } bridge_state_e;

  typedef enum logic [1:0] {
    TERM_NONE    = 2'd0,
    TERM_ACK     = 2'd1,
    TERM_ERR     = 2'd2,
    TERM_TIMEOUT = 2'd3
  } term_cause_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Wide enough for the largest legal timeout of 65535 cycles.
  localparam int TIMER_WIDTH = 16;

  // Ack wins over err, and either wins over a timeout in the same cycle.
  function automatic term_cause_e resolve_termination(input logic ack,
                                                      input logic err,
                                                      input logic expired);
    if (ack) begin
      return TERM_ACK;
    end else if (err) begin
      return TERM_ERR;
    end else if (expired) begin
      return TERM_TIMEOUT;
    end
    return TERM_NONE;
  endfunction

endpackage

// File: rtl/memory_wishbone_bridge_if.sv
// Wishbone B4 classic bus between the bridge (master) and a slave.
interface memory_wishbone_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;
  logic                    wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/memory_wishbone_bridge_bus_timeout_counter.sv
// Saturating cycle counter that flags when a Wishbone cycle has run for
// LIMIT_CYCLES cycles.
module bus_timeout_counter
  import memory_wishbone_bridge_pkg::*;
#(
  parameter int LIMIT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_WIDTH-1:0] LAST = TIMER_WIDTH'(LIMIT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] count;

  // NOTE: state updates use <= so every flop samples pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + TIMER_WIDTH'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/memory_wishbone_bridge.sv
// Bridges the cache's level-sensitive memory request into single Wishbone
// classic cycles, with timeout abort and a one-cycle response pulse.
module memory_wishbone_bridge
  import memory_wishbone_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  memory_read_request,
  input  logic                  memory_write_request,
  input  logic [ADDR_WIDTH-1:0] memory_addr,
  input  logic [DATA_WIDTH-1:0] memory_write_data,
  output logic                  memory_response,
  output logic [DATA_WIDTH-1:0] memory_read_data,
  output logic                  memory_error,

  memory_wishbone_bridge_if.master wb
);

  bridge_state_e state;
  bridge_state_e state_next;
  term_cause_e   cause;

  logic                  capture;
  logic                  terminate;
  logic                  timer_expired;

  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  we_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    terminate  = 1'b0;
    cause      = resolve_termination(wb.wb_ack_i, wb.wb_err_i, timer_expired);

    case (state)
      ST_IDLE: begin
        if (memory_read_request || memory_write_request) begin
          capture    = 1'b1;
          state_next = ST_BUS;
        end
      end
      ST_BUS: begin
        // Dropping the request here does not abort: the cycle runs to its end.
        if (cause != TERM_NONE) begin
          terminate  = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_HOLD;
      // The requester clears its level request at the response edge; this
      // cycle keeps a stale request from launching a second access.
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are few and all feed visible outputs, so
  // they are all reset to give known bus and response values out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        adr_q <= memory_addr;
        dat_q <= memory_write_data;
        // A simultaneous read and write is issued as a write.
        we_q  <= memory_write_request;
      end
      if (terminate) begin
        err_q <= (cause != TERM_ACK);
        if (!we_q) begin
          rdata_q <= (cause == TERM_ACK) ? wb.wb_dat_i : '0;
        end
      end
    end
  end

  bus_timeout_counter #(
    .LIMIT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (capture),
    .enable  (state == ST_BUS),
    .expired (timer_expired)
  );

  // Cycle and strobe follow the state register, so an asynchronous reset
  // drops them in the same cycle.
  assign wb.wb_cyc_o = (state == ST_BUS);
  assign wb.wb_stb_o = (state == ST_BUS);
  assign wb.wb_sel_o = (state == ST_BUS) ? '1 : '0;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;

  assign memory_response  = (state == ST_RESP);
  assign memory_error     = (state == ST_RESP) && err_q;
  assign memory_read_data = rdata_q;

endmodule

// File: tb/tb_memory_wishbone_bridge.sv
// Self-checking bench for memory_wishbone_bridge: a scripted Wishbone slave
// and a response scoreboard fed as each access is launched.
module tb_memory_wishbone_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;

  logic          clk;
  logic          rst_n;
  logic          memory_read_request;
  logic          memory_write_request;
  logic [AW-1:0] memory_addr;
  logic [DW-1:0] memory_write_data;
  logic          memory_response;
  logic [DW-1:0] memory_read_data;
  logic          memory_error;

  memory_wishbone_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

  memory_wishbone_bridge #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .memory_read_request  (memory_read_request),
    .memory_write_request (memory_write_request),
    .memory_addr          (memory_addr),
    .memory_write_data    (memory_write_data),
    .memory_response      (memory_response),
    .memory_read_data     (memory_read_data),
    .memory_error         (memory_error),
    .wb                   (wb)
  );

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  resp_t         exp_q[$];
  int            n_checks;
  int            n_fail;
  logic [DW-1:0] model_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard side: every response pulse is matched to the oldest launch.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && memory_response) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", memory_error, e.err);
        check("resp_rdata", memory_read_data, e.rdata);
      end
    end
    if (memory_error && !memory_response) check("err_without_resp", 1, 0);
  end

  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int mode, input int delay,
                           input logic [DW-1:0] sdata, input bit keep_req);
    int   waited;
    int   cycles;
    int   unstable;
    resp_t e;
    if (!wr) model_rdata = (mode == M_ACK) ? sdata : '0;
    e.err   = (mode != M_ACK);
    e.rdata = model_rdata;
    exp_q.push_back(e);

    @(posedge clk); #1;
    memory_read_request  = rd;
    memory_write_request = wr;
    memory_addr          = addr;
    memory_write_data    = wdata;
    wb.wb_dat_i          = sdata;

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!wb.wb_cyc_o && waited < 8);
    check({tag, "_latency"}, waited, 2);
    check({tag, "_we"}, wb.wb_we_o, wr);
    check({tag, "_adr"}, wb.wb_adr_o, addr);
    check({tag, "_dat"}, wb.wb_dat_o, wdata);
    check({tag, "_sel"}, wb.wb_sel_o, 4'hF);

    cycles   = 0;
    unstable = 0;
    while (wb.wb_cyc_o && cycles < 300) begin
      cycles++;
      if (wb.wb_adr_o !== addr || wb.wb_we_o !== wr || wb.wb_dat_o !== wdata ||
          wb.wb_stb_o !== 1'b1) unstable++;
      if (mode != M_NONE && cycles == delay + 1) begin
        if (mode == M_ACK) wb.wb_ack_i = 1'b1;
        else               wb.wb_err_i = 1'b1;
      end
      @(posedge clk); #1;
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
      @(negedge clk);
    end
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_bus_cycles"}, cycles, (mode == M_NONE) ? TO : delay + 1);
    check({tag, "_resp"}, memory_response, 1);

    if (!keep_req) begin
      @(posedge clk); #1;
      memory_read_request  = 1'b0;
      memory_write_request = 1'b0;
    end
  endtask

  initial begin
    int    waited;
    int    kind;
    resp_t e;
    rst_n                = 1'b0;
    memory_read_request  = 1'b0;
    memory_write_request = 1'b0;
    memory_addr          = '0;
    memory_write_data    = '0;
    wb.wb_ack_i          = 1'b0;
    wb.wb_err_i          = 1'b0;
    wb.wb_dat_i          = '0;
    model_rdata          = '0;
    n_checks             = 0;
    n_fail               = 0;

    #12;
    check("rst_cyc", wb.wb_cyc_o, 0);
    check("rst_stb", wb.wb_stb_o, 0);
    check("rst_we", wb.wb_we_o, 0);
    check("rst_adr", wb.wb_adr_o, 0);
    check("rst_dat", wb.wb_dat_o, 0);
    check("rst_sel", wb.wb_sel_o, 0);
    check("rst_resp", memory_response, 0);
    check("rst_err", memory_error, 0);
    check("rst_rdata", memory_read_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_access("rd_1000", 1, 0, 32'h0000_1000, '0, M_ACK, 2, 32'hDEAD_BEEF, 0);
    check("rd_1000_rdata_held", memory_read_data, 32'hDEAD_BEEF);

    do_access("wr_2004", 0, 1, 32'h0000_2004, 32'h1234_5678, M_ACK, 0, 32'hBAAD_F00D, 0);
    check("wr_2004_rdata_kept", memory_read_data, 32'hDEAD_BEEF);

    do_access("rdwr_10", 1, 1, 32'h0000_0010, 32'hA5A5_0F0F, M_ACK, 1, 32'h1111_2222, 0);

    do_access("timeout", 1, 0, 32'h0000_0020, '0, M_NONE, 0, 32'h5555_AAAA, 0);
    check("timeout_rdata_zero", memory_read_data, 0);

    // Error read; the level request stays high through RESP and HOLD.
    do_access("err_rd", 1, 0, 32'h0000_0030, '0, M_ERR, 1, 32'h7777_8888, 1);
    model_rdata = 32'hCAFE_F00D;
    e.err   = 1'b0;
    e.rdata = model_rdata;
    exp_q.push_back(e);
    wb.wb_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    check("hold_ignores_req", wb.wb_cyc_o, 0);
    @(negedge clk);
    check("idle_before_accept", wb.wb_cyc_o, 0);
    @(negedge clk);
    check("accept_after_hold", wb.wb_cyc_o, 1);
    wb.wb_ack_i = 1'b1;
    @(posedge clk); #1;
    wb.wb_ack_i         = 1'b0;
    memory_read_request = 1'b0;
    @(negedge clk);
    check("reaccept_resp", memory_response, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 2);
      do_access("rand", (kind != 1), (kind != 0), $urandom & 32'hFFFF_FFFC, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0);
    end

    // Reset in the middle of a bus cycle.
    @(posedge clk); #1;
    memory_read_request = 1'b1;
    memory_addr         = 32'h0000_3000;
    wb.wb_dat_i         = 32'h9999_9999;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!wb.wb_cyc_o && waited < 8);
    check("rst_bus_entered", wb.wb_cyc_o, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_drops_cyc", wb.wb_cyc_o, 0);
    check("rst_drops_stb", wb.wb_stb_o, 0);
    check("rst_clears_rdata", memory_read_data, 0);
    model_rdata         = '0;
    memory_read_request = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_resp", memory_response, 0);
    end
    rst_n = 1'b1;

    do_access("post_rst", 1, 0, 32'h0000_0040, '0, M_ACK, 0, 32'h0BAD_CAFE, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_wishbone_bridge.md
MEMORY_WISHBONE_BRIDGE -- requirements
Module: memory_wishbone_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the memory data path and Wishbone data bus.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: width of the memory address and Wishbone address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles allowed before a forced abort (range 1..65535).
REQ-004 SHALL provide port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL provide port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL provide port memory_read_request, input, 1: level read request from the cache request multiplexer.
REQ-007 SHALL provide port memory_write_request, input, 1: level write request from the multiplexer.
REQ-008 SHALL provide port memory_addr, input, ADDR_WIDTH: byte address, held stable while a request is high.
REQ-009 SHALL provide port memory_write_data, input, DATA_WIDTH: write data, held stable with the request.
REQ-010 SHALL provide port memory_response, output, 1: single-cycle completion pulse.
REQ-011 SHALL provide port memory_read_data, output, DATA_WIDTH: read data, valid in the memory_response cycle.
REQ-012 SHALL provide port memory_error, output, 1: pulses with memory_response when the access ended by wb_err_i or timeout.
REQ-013 SHALL provide Wishbone B4 classic master ports wb_cyc_o, wb_stb_o, wb_we_o (output, 1 each), wb_adr_o (output, ADDR_WIDTH), wb_dat_o (output, DATA_WIDTH), wb_sel_o (output, DATA_WIDTH/8).
REQ-014 SHALL provide Wishbone inputs wb_dat_i (DATA_WIDTH), wb_ack_i (1), wb_err_i (1).

Function
REQ-015 SHALL implement FSM states IDLE, BUS, RESP, HOLD.
REQ-016 IDLE: when read or write request is high, SHALL register address, data and direction, and enter BUS next cycle.
REQ-017 Simultaneous read and write requests SHALL be treated as a write (wb_we_o=1).
REQ-018 BUS: wb_cyc_o=wb_stb_o=1, wb_sel_o all ones, wb_adr_o/wb_dat_o/wb_we_o from registered values, stable until termination.
REQ-019 BUS SHALL terminate on wb_ack_i, wb_err_i, or timeout counter reaching TIMEOUT_CYCLES-1; ack has priority over err if both high.
REQ-020 On termination SHALL drop wb_cyc_o/wb_stb_o the following cycle, capture wb_dat_i on ack of a read (else 0), and enter RESP.
REQ-021 RESP: memory_response=1 for exactly one cycle, memory_error=1 if terminated by err or timeout; then HOLD.
REQ-022 HOLD: SHALL ignore requests for exactly one cycle (requester clears its level request at the response edge), then IDLE.
REQ-023 Minimum latency: request seen in cycle N -> BUS N+1 -> ack in N+1 -> memory_response in N+2.
REQ-024 memory_read_data SHALL hold its last value outside RESP; writes SHALL not alter it.
REQ-025 Timeout counter SHALL clear on entry to BUS and saturate, never wrap.
REQ-026 Request deassertion during BUS SHALL NOT abort the Wishbone cycle; response is still generated.

Reset
REQ-027 On rst_n low, asynchronously: state IDLE, wb_cyc_o/wb_stb_o/wb_we_o=0, wb_adr_o/wb_dat_o=0, wb_sel_o=0, memory_response=0, memory_error=0, memory_read_data=0, counter=0.
REQ-028 Reset mid-cycle SHALL drop wb_cyc_o immediately; no response SHALL be issued for the aborted access.
REQ-029 Reset release SHALL resume in IDLE, accepting a request from the first clock edge after release.

Structure
REQ-030 FSM state encoding and default TIMEOUT_CYCLES SHALL live in the shared core package.
REQ-031 Timeout counter SHALL be a sub-module bus_timeout_counter (clear, enable, expired outputs).

Verification
REQ-032 Read 0x0000_1000, slave acks 2 cycles later with 0xDEAD_BEEF -> one memory_response pulse, memory_read_data=0xDEAD_BEEF, memory_error=0.
REQ-033 Write 0x0000_2004 data 0x1234_5678 -> wb_we_o=1, wb_dat_o=0x1234_5678, wb_sel_o=0xF, one response, read data unchanged.
REQ-034 Read and write high together at 0x10 -> write cycle issued (wb_we_o=1).
REQ-035 TIMEOUT_CYCLES=4, slave never acks -> cyc drops after 4 BUS cycles, response with memory_error=1, read data 0.
REQ-036 wb_err_i on read -> response with memory_error=1; next request accepted only after the HOLD cycle.
REQ-037 rst_n low during BUS -> wb_cyc_o=0 same cycle, no memory_response, IDLE after release.
